// File: rtl/bcd_pkg.sv
// Package: bcd_pkg
// Shared types and constants for the multi-decade BCD up/down counter.
//   bcd_digit_t : one packed BCD decade (4 bits)
//   BCD_MAX     : largest legal decade value (9)
//   BCD_MIN     : smallest legal decade value (0)
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Values above 9 cannot be stored as BCD; they collapse to 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t val);
        return (val > BCD_MAX) ? BCD_MAX : val;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Interface: bcd_updown_counter_if
// Control and result bundle of the BCD up/down counter.
//   en    : count enable
//   load  : synchronous parallel load
//   dir   : 0 = up, 1 = down
//   data  : load value, digit i at [4i+3:4i]
//   sat   : saturate instead of wrap (only when BCD_CNT_SAT_EN is defined)
//   count : current BCD value, same packing as data
//   sup   : overflow pulse
//   inf   : underflow pulse
// modport master drives the controls, modport slave is the counter side.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic                  dir;
    logic [4*DIGITS-1:0]   data;
`ifdef BCD_CNT_SAT_EN
    logic                  sat;
`endif
    logic [4*DIGITS-1:0]   count;
    logic                  sup;
    logic                  inf;

`ifdef BCD_CNT_SAT_EN
    modport master (output en, load, dir, data, sat, input count, sup, inf);
    modport slave  (input en, load, dir, data, sat, output count, sup, inf);
`else
    modport master (output en, load, dir, data, input count, sup, inf);
    modport slave  (input en, load, dir, data, output count, sup, inf);
`endif

endinterface

// File: rtl/bcd_digit.sv
// Module: bcd_digit
// One BCD decade register.
//   clk      : rising-edge clock
//   rst_n    : asynchronous reset, active high (clears the digit)
//   step_en  : advance this digit one step this edge
//   dir      : 0 = increment, 1 = decrement
//   load     : take load_val (clamped to 9) this edge, overrides step_en
//   load_val : parallel load value
//   digit    : current decade value
//   is_max   : digit counts as 9 for carry purposes (9 or illegal >9)
//   is_min   : digit is 0
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    input  logic       dir,
    input  logic       load,
    input  bcd_digit_t load_val,
    output bcd_digit_t digit,
    output logic       is_max,
    output logic       is_min
);

    // An illegal value behaves as 9: it wraps to 0 going up and snaps
    // to 9 going down.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_clamp(load_val);
        end else if (step_en) begin
            if (!dir) begin
                digit <= (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
            end else if (digit == BCD_MIN) begin
                digit <= BCD_MAX;
            end else if (digit > BCD_MAX) begin
                digit <= BCD_MAX;
            end else begin
                digit <= digit - 4'd1;
            end
        end
    end

    assign is_max = (digit >= BCD_MAX);
    assign is_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Module: bcd_updown_counter
// Parametrised multi-decade BCD up/down counter with parallel load and
// registered overflow/underflow pulses.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active high (count and flags cleared)
//   bus   : bcd_updown_counter_if.slave (en, load, dir, data, [sat],
//           count, sup, inf)
// Optional feature macro: BCD_CNT_SAT_EN adds the sat input; with sat=1
// the counter holds at all-9s / all-0s instead of wrapping.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_updown_counter_if.slave  bus
);

    bcd_digit_t          digit_q [DIGITS];
    logic [DIGITS-1:0]   is_max;
    logic [DIGITS-1:0]   is_min;
    logic [DIGITS-1:0]   up_ok;
    logic [DIGITS-1:0]   dn_ok;
    logic [DIGITS-1:0]   step_en;
    logic                all_max;
    logic                all_min;
    logic                hold;
    logic                step_any;
    logic                sup_q;
    logic                inf_q;

    assign all_max = &is_max;
    assign all_min = &is_min;

`ifdef BCD_CNT_SAT_EN
    assign hold = bus.sat & (bus.dir ? all_min : all_max);
`else
    assign hold = 1'b0;
`endif

    assign step_any = bus.en & ~bus.load & ~hold;

    // Lookahead: each digit's enable is a flat AND of all lower terminal
    // flags, so a full carry/borrow settles within one cycle.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign up_ok[i] = 1'b1;
            assign dn_ok[i] = 1'b1;
        end else begin : g_upper
            assign up_ok[i] = &is_max[i-1:0];
            assign dn_ok[i] = &is_min[i-1:0];
        end

        assign step_en[i] = step_any & (bus.dir ? dn_ok[i] : up_ok[i]);

        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step_en  (step_en[i]),
            .dir      (bus.dir),
            .load     (bus.load),
            .load_val (bus.data[4*i +: 4]),
            .digit    (digit_q[i]),
            .is_max   (is_max[i]),
            .is_min   (is_min[i])
        );

        assign bus.count[4*i +: 4] = digit_q[i];
    end

    // Flags mark the edge that passes a full-range boundary; in saturate
    // mode they repeat on every edge that is held at the boundary.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sup_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            sup_q <= bus.en & ~bus.load & ~bus.dir & all_max;
            inf_q <= bus.en & ~bus.load &  bus.dir & all_min;
        end
    end

    assign bus.sup = sup_q;
    assign bus.inf = inf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Testbench: tb_bcd_updown_counter
// Scoreboard bench for a 3-decade bcd_updown_counter. Each stimulus edge
// queues its hand-computed expected count/sup/inf; a monitor pops and
// compares on the following falling edge. Async reset is checked directly.
// Defining BCD_CNT_SAT_EN adds the saturate vectors.
module tb_bcd_updown_counter;

    localparam int DIGITS = 3;

    typedef struct {
        logic [4*DIGITS-1:0] count;
        logic                sup;
        logic                inf;
        int                  id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;
    int   vec_id;
    exp_t sb [$];

    bcd_updown_counter_if #(.DIGITS(DIGITS)) bus ();

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's controls just after the falling edge and queue
    // the value the counter must show after the next rising edge.
    task automatic applyStimulus(input logic ld, input logic e, input logic d,
                                 input logic [4*DIGITS-1:0] dat,
                                 input logic [4*DIGITS-1:0] exp_count,
                                 input logic exp_sup, input logic exp_inf);
        exp_t x;
        @(negedge clk);
        #1;
        bus.load = ld;
        bus.en   = e;
        bus.dir  = d;
        bus.data = dat;
        vec_id++;
        x.count = exp_count;
        x.sup   = exp_sup;
        x.inf   = exp_inf;
        x.id    = vec_id;
        sb.push_back(x);
    endtask

    // Immediate comparison, used where no clock edge is involved.
    task automatic checkOutput(input string name,
                               input logic [4*DIGITS-1:0] exp_count,
                               input logic exp_sup, input logic exp_inf);
        checks_total++;
        if (bus.count !== exp_count || bus.sup !== exp_sup || bus.inf !== exp_inf)
            $display("[TB] FAIL %s: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                     name, bus.count, bus.sup, bus.inf, exp_count, exp_sup, exp_inf);
        else
            checks_passed++;
    endtask

    // Monitor: one queued expectation per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks_total++;
            if (bus.count !== x.count || bus.sup !== x.sup || bus.inf !== x.inf)
                $display("[TB] FAIL vec%0d: got count=%h sup=%b inf=%b, expected count=%h sup=%b inf=%b",
                         x.id, bus.count, bus.sup, bus.inf, x.count, x.sup, x.inf);
            else
                checks_passed++;
        end
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        vec_id        = 0;
        rst_n     = 1'b1;
        bus.en    = 1'b0;
        bus.load  = 1'b0;
        bus.dir   = 1'b0;
        bus.data  = '0;
`ifdef BCD_CNT_SAT_EN
        bus.sat   = 1'b0;
`endif
        #2;
        checkOutput("reset_state", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;

        // Count to 037, then reset between edges.
        applyStimulus(1, 0, 0, 12'h035, 12'h035, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h036, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h037, 0, 0);
        @(negedge clk);
        #1;
        bus.en = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_async", 12'h000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(0, 1, 0, 12'h000, 12'h001, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h002, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h003, 0, 0);

        // Up wrap with a single-cycle sup pulse.
        applyStimulus(1, 0, 0, 12'h998, 12'h998, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h999, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h000, 1, 0);
        applyStimulus(0, 0, 0, 12'h000, 12'h000, 0, 0);

        // Down with borrow cascade, then underflow wrap.
        applyStimulus(1, 0, 1, 12'h100, 12'h100, 0, 0);
        applyStimulus(0, 1, 1, 12'h000, 12'h099, 0, 0);
        applyStimulus(0, 1, 1, 12'h000, 12'h098, 0, 0);
        applyStimulus(1, 0, 1, 12'h000, 12'h000, 0, 0);
        applyStimulus(0, 1, 1, 12'h000, 12'h999, 0, 1);
        applyStimulus(0, 1, 1, 12'h000, 12'h998, 0, 0);

        // Load clamping and load-over-enable priority.
        applyStimulus(1, 1, 0, 12'h0B5, 12'h095, 0, 0);
        applyStimulus(1, 1, 1, 12'hFAB, 12'h999, 0, 0);
        applyStimulus(1, 1, 0, 12'h9C3, 12'h993, 0, 0);

        // Enable and direction toggling.
        applyStimulus(1, 0, 0, 12'h050, 12'h050, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h051, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h052, 0, 0);
        applyStimulus(0, 0, 0, 12'h000, 12'h052, 0, 0);
        applyStimulus(0, 1, 1, 12'h000, 12'h051, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h052, 0, 0);

`ifdef BCD_CNT_SAT_EN
        // Saturation at both ends, then wrap again once sat drops.
        bus.sat = 1'b1;
        applyStimulus(1, 0, 0, 12'h999, 12'h999, 0, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h999, 1, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h999, 1, 0);
        applyStimulus(0, 1, 0, 12'h000, 12'h999, 1, 0);
        applyStimulus(1, 0, 1, 12'h000, 12'h000, 0, 0);
        applyStimulus(0, 1, 1, 12'h000, 12'h000, 0, 1);
        applyStimulus(0, 1, 1, 12'h000, 12'h000, 0, 1);
        @(negedge clk);
        #1;
        bus.sat = 1'b0;
        bus.en  = 1'b0;
        applyStimulus(0, 1, 1, 12'h000, 12'h999, 0, 1);
`endif

        applyStimulus(0, 0, 0, 12'h000, 12'h052, 0, 0);
`ifdef BCD_CNT_SAT_EN
        sb.pop_back();
        vec_id--;
        sb.push_back('{count: 12'h999, sup: 1'b0, inf: 1'b0, id: vec_id + 1});
        vec_id++;
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks_total++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
